regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the 2R/1W regfile in the pipeline's decode/writeback path.
- Adds the following over the 2R/1W file:
  - configurable width, depth and port counts
  - multiple write ports with fixed priority
  - optional write-to-read bypass
  - synchronous reset that sweeps all entries to zero through a clear state machine, with a ready flag
- Feeds the ID-stage operand muxes; a dual-issue writeback drives several write ports.

Parameters:
- XLEN, 32, data width per register
- NREGS, 32, number of registers (>=2, power of two)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
- AW (localparam), $clog2(NREGS), address width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- clear_req  input  1  request a full re-clear sweep
- ready  output  1  file initialised; writes accepted, reads valid
- we  input  NWR  per-port write enable
- waddr  input  NWR*AW  write addresses, port i at [i*AW +: AW]
- wdata  input  NWR*XLEN  write data, port i at [i*XLEN +: XLEN]
- raddr  input  NRD*AW  read addresses, port j at [j*AW +: AW]
- rdata  output  NRD*XLEN  read data, port j at [j*XLEN +: XLEN]

Behaviour:
- States: CLEAR, READY.
  - rst=1 forces CLEAR with ptr=0, evaluated on the clock edge.
  - Reset values: ready=0, rdata=0, ptr=0.
- CLEAR state:
  - Each cycle writes 0 to regs[ptr], then ptr++.
  - When ptr==NREGS-1 is written, the next state is READY.
  - Timing: ready rises exactly NREGS cycles after the first edge with rst=0, e.g. 32 cycles at default.
  - rst held high keeps ptr at 0.
  - All we ignored; clear_req ignored; every rdata reads 0.
- READY state:
  - ready=1.
  - clear_req=1 at an edge: enter CLEAR with ptr=0. Writes in that same cycle are discarded.
  - rst mid-sweep restarts the sweep from ptr=0.
- Write:
  - On a rising edge in READY (no clear_req), regs[waddr[i]] <= wdata[i] for each i with we[i].
  - ZERO_REG=1: writes to address 0 are dropped.
  - Several ports hitting the same address: the highest-index port wins; lower ports to that address are dropped.
- Read:
  - Combinational from the current array state.
  - ZERO_REG=1 and raddr==0: rdata=0.
  - BYPASS=1: if any write port in the current cycle has we=1, matching address and the write is legal (READY, no clear_req, address nonzero when ZERO_REG), rdata takes the wdata of the highest-index matching port.
  - BYPASS=0: rdata shows the old value; the new value is visible from the cycle after the edge.
- No arithmetic beyond the ptr increment. ptr is AW bits wide and never wraps, because the state exits CLEAR at NREGS-1.

Decomposition:
- Package regfile_pkg:
  - state enum {CLEAR, READY}
  - the clog2-based address-width helper
- Sub-module regfile_clear_ctrl:
  - owns the FSM, ptr and ready
  - outputs clr_we/clr_addr to the array write mux
- The top level holds the array, the write-priority logic and the read/bypass muxes, all generate-looped over NWR/NRD.

Test Plan:
- Reset sweep: preload garbage via a backdoor, pulse rst for 3 cycles -> ready=0 for exactly 32 cycles after the rst drop, then ready=1; all 32 reads return 0.
- Basic write/read: in READY, port0 writes 0xDEADBEEF to r5 -> the next cycle rdata0 with raddr0=5 gives 0xDEADBEEF; r0 write of 0x1234 -> r0 still reads 0.
- Write conflict: port0 writes r7=0x11111111 and port1 writes r7=0x22222222 in the same cycle -> r7 reads 0x22222222; with BYPASS=1 the same-cycle read also gives 0x22222222.
- Bypass on/off: write r3=0xA5A5A5A5 while raddr1=3 -> same cycle rdata1=0xA5A5A5A5 with BYPASS=1, old value with BYPASS=0; both give 0xA5A5A5A5 the next cycle.
- Clear during operation: r9=0x55 in READY; assert clear_req together with a port0 write r10=0x77 -> ready=0 for 32 cycles; r9 and r10 then read 0; writes during the sweep have no effect.
- Reset mid-sweep: assert rst at sweep cycle 15 -> ptr restarts at 0 and ready rises 32 cycles after the rst drop.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and helpers for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  // Address width for a given register count; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clear_ctrl.sv
// ============================================================================
// Module      : regfile_clear_ctrl
// Description : Clear-sweep state machine; zeroes one entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] c_last = AW'(NREGS - 1);

  rf_state_e     r_state;
  logic [AW-1:0] r_ptr;
  logic          r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          // Leave on the last entry so the pointer never wraps.
          if (r_ptr == c_last) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        READY: begin
          if (clear_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign clr_we   = (r_state == CLEAR);
  assign clr_addr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with priority writes,
//               optional write-to-read bypass and a clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_req,
  output logic                ready,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_ready;
  logic            w_clr_we;
  logic [AW-1:0]   w_clr_addr;
  logic [NWR-1:0]  w_wlegal;

  regfile_clear_ctrl #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .ready     (w_ready),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr)
  );

  assign ready = w_ready;

  // A port write is legal only in READY with no clear pending and not to r0.
  for (genvar i = 0; i < NWR; i++) begin : g_wr
    logic [AW-1:0] w_wa;
    assign w_wa        = waddr[i*AW +: AW];
    assign w_wlegal[i] = we[i] && w_ready && !clear_req && !rst &&
                         !((ZERO_REG != 0) && (w_wa == '0));
  end

  // Later loop iterations override earlier ones: highest port index wins.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_regs[w_clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (w_wlegal[i]) begin
          r_regs[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_val;
    assign w_ra = raddr[j*AW +: AW];

    always_comb begin
      w_val = r_regs[w_ra];
      if (BYPASS != 0) begin
        for (int i = 0; i < NWR; i++) begin
          if (w_wlegal[i] && (waddr[i*AW +: AW] == w_ra)) begin
            w_val = wdata[i*XLEN +: XLEN];
          end
        end
      end
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_val = '0;
      end
      if (!w_ready) begin
        w_val = '0;
      end
    end

    assign rdata[j*XLEN +: XLEN] = w_val;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp (bypass on/off).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  localparam int c_aw = 5;
  localparam int c_xl = 32;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata_b;
  logic [63:0] rdata_n;
  logic        ready_b;
  logic        ready_n;

  int n_checks;
  int n_errors;
  int cnt;

  regfile_mp #(.BYPASS(1)) u_dut_byp (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_b),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_b)
  );

  regfile_mp #(.BYPASS(0)) u_dut_nob (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_n),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    we[p]               = en;
    waddr[p*c_aw +: c_aw] = a;
    wdata[p*c_xl +: c_xl] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    raddr[p*c_aw +: c_aw] = a;
  endtask

  // Counts edges until both instances report ready; bounded.
  task automatic wait_ready(input string tag);
    cnt = 0;
    while (!(ready_b && ready_n) && cnt < 200) begin
      tick();
      cnt++;
    end
    check(tag, cnt, 32);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    clear_req = 1'b0;
    we        = '0;
    waddr     = '0;
    wdata     = '0;
    raddr     = '0;
    set_rd(0, 5'd4);
    repeat (3) tick();
    check("reset_ready", {31'd0, ready_b}, 32'd0);
    check("reset_rdata", rdata_b[31:0], 32'd0);

    rst = 1'b0;
    wait_ready("first_sweep_len");

    // Load junk, then confirm a reset sweep wipes it.
    for (int a = 1; a < 32; a++) begin
      set_wr(0, 1'b1, a[4:0], 32'hC0DE_0000 + a);
      tick();
    end
    set_wr(0, 1'b0, 5'd0, 32'd0);
    set_rd(0, 5'd17);
    #1;
    check("junk_r17", rdata_b[31:0], 32'hC0DE_0011);

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    wait_ready("rst_sweep_len");
    for (int a = 0; a < 32; a++) begin
      set_rd(0, a[4:0]);
      @(negedge clk);
      check("swept_zero", rdata_b[31:0], 32'd0);
    end
    tick();

    // Basic write then read next cycle; r0 stays zero even same-cycle.
    set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    set_wr(0, 1'b1, 5'd0, 32'h0000_1234);
    set_rd(0, 5'd5);
    set_rd(1, 5'd0);
    #1;
    check("r5_read", rdata_n[31:0], 32'hDEAD_BEEF);
    check("r0_bypass", rdata_b[63:32], 32'd0);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'd0);
    #1;
    check("r0_after", rdata_b[63:32], 32'd0);

    // Write conflict: port 1 wins, also on the bypass path.
    set_wr(0, 1'b1, 5'd7, 32'h1111_1111);
    set_wr(1, 1'b1, 5'd7, 32'h2222_2222);
    set_rd(0, 5'd7);
    #1;
    check("conflict_byp", rdata_b[31:0], 32'h2222_2222);
    check("conflict_nobyp_old", rdata_n[31:0], 32'd0);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'd0);
    set_wr(1, 1'b0, 5'd0, 32'd0);
    #1;
    check("conflict_byp_next", rdata_b[31:0], 32'h2222_2222);
    check("conflict_nobyp_next", rdata_n[31:0], 32'h2222_2222);

    // Bypass on/off on read port 1.
    set_wr(0, 1'b1, 5'd3, 32'hA5A5_A5A5);
    set_rd(1, 5'd3);
    #1;
    check("bypass_same", rdata_b[63:32], 32'hA5A5_A5A5);
    check("nobypass_same", rdata_n[63:32], 32'd0);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'd0);
    #1;
    check("bypass_next", rdata_b[63:32], 32'hA5A5_A5A5);
    check("nobypass_next", rdata_n[63:32], 32'hA5A5_A5A5);

    // Clear during operation; the accompanying write and sweep writes are lost.
    set_wr(0, 1'b1, 5'd9, 32'h0000_0055);
    tick();
    set_wr(0, 1'b1, 5'd10, 32'h0000_0077);
    set_rd(0, 5'd9);
    set_rd(1, 5'd10);
    clear_req = 1'b1;
    #1;
    check("clr_pre_r9", rdata_n[31:0], 32'h0000_0055);
    check("clr_no_byp", rdata_b[63:32], 32'd0);
    tick();
    clear_req = 1'b0;
    set_wr(0, 1'b1, 5'd11, 32'h0000_0099);
    #1;
    check("clr_ready_low", {31'd0, ready_b}, 32'd0);
    check("clr_rdata_zero", rdata_b[31:0], 32'd0);
    wait_ready("clr_sweep_len");
    set_wr(0, 1'b0, 5'd0, 32'd0);
    set_rd(0, 5'd10);
    set_rd(1, 5'd11);
    #1;
    check("clr_r10", rdata_n[31:0], 32'd0);
    check("clr_r11", rdata_n[63:32], 32'd0);
    set_rd(0, 5'd9);
    #1;
    check("clr_r9", rdata_n[31:0], 32'd0);

    // Reset at sweep cycle 15 restarts the full sweep.
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (15) tick();
    check("mid_ready_low", {31'd0, ready_b}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready("mid_rst_sweep_len");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
